display_scan: RTL and testbench
===============================

Name: display_scan

Overview:
- Time-multiplexed N-digit seven-segment display driver for the lab display path.
- Successor to the fixed 2-to-4 enable decoder:
  - digit-select decoder is parametrised to NDIGIT outputs;
  - adds a refresh divider, scan state, frame-coherent data snapshot, per-digit blanking and decimal points, and output polarity selection.
- Sits between the system's display data registers and the board pins (anodes, segments, dp).

Parameters:
- NDIGIT, 8: number of digits scanned; legal range 1..16.
- DIV, 100000: clk cycles each digit stays lit; must be >= 2.
- ACTIVE_LOW, 1: 1 inverts an, seg and dp_out at the pins; 0 drives them active-high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  scan enable. 0 = hold scan state and blank all outputs.
- data  in  4*NDIGIT  hex nibble per digit; digit i is data[4i+3:4i].
- dp  in  NDIGIT  decimal point request per digit.
- blank  in  NDIGIT  1 = digit i is dark for its whole slot.
- an  out  NDIGIT  one-hot digit select (polarity per ACTIVE_LOW).
- seg  out  7  segments {g,f,e,d,c,b,a} (polarity per ACTIVE_LOW).
- dp_out  out  1  decimal point segment (polarity per ACTIVE_LOW).
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Clock, reset and polarity:
  - One clock: clk.
  - Reset is asynchronous and active-high on port reset.
  - All state is cleared immediately when reset asserts, independent of clk.
- Reset values:
  - cnt=0, idx=0, shadow data/dp/blank=0, frame_tick=0.
  - an, seg and dp_out are at their inactive level: all 1s if ACTIVE_LOW=1, all 0s otherwise.
- Divider:
  - cnt counts 0..DIV-1 and increments only when en=1.
  - When cnt=DIV-1 and en=1, cnt wraps to 0 and idx advances.
  - idx wraps from NDIGIT-1 to 0.
  - Width of cnt is $clog2(DIV); width of idx is max(1,$clog2(NDIGIT)).
- Frame start:
  - Condition: en=1 and idx=0 and cnt=0.
  - On that cycle, data, dp and blank are captured into shadow registers.
  - frame_tick is 1 on the following cycle, registered, for exactly one cycle.
  - Data changes mid-frame are not visible until the next frame start, so there is no tearing.
- en=0:
  - cnt, idx and shadow hold their values.
  - On the next edge, an, seg and dp_out go inactive.
  - When en returns to 1, scanning resumes from the held cnt/idx.
  - No frame start occurs unless cnt=0 and idx=0.
- Output stage:
  - an, seg and dp_out are registered.
  - The values after edge k+1 are a function of en, idx and shadow as held between edges k and k+1.
  - This gives a 1-cycle latency from scan state to pins.
- Digit select:
  - an is the one-hot decode of idx, gated by en and by ~shadow_blank[idx].
  - If the digit is blanked, an, seg and dp_out are all inactive.
- Segment decode:
  - Standard hex table, active-high before inversion.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - dp_out = shadow_dp[idx].
- NDIGIT=1: idx is constantly 0 and every slot wrap is a frame start.
- Reset mid-scan: outputs go inactive immediately (asynchronous). The first frame starts on the first en=1 cycle after release.

Decomposition:
- Shared package display_pkg:
  - typedef seg_t (logic [6:0]);
  - the hex-to-segment constant table, with function hex2seg returning seg_t;
  - localparam SEG_BLANK.
- One sub-module, onehot_decoder:
  - parameters N and W;
  - ports in [W-1:0], en, out [N-1:0];
  - out = en ? (1<<in) : 0.
  - This is the generalised digit-select decoder.
- Divider, scan counter, shadow registers and output registers stay in display_scan.

Test Plan (NDIGIT=4, DIV=4, ACTIVE_LOW=1 unless stated):
- Reset, then release with en=1, data=16'h3210, dp=0, blank=0 ->
  - an=4'b1111 and seg=7'h7F during reset;
  - frame_tick pulses 1 cycle after release;
  - an=1110 and seg=~3F=7'h40 from the edge after the capture;
  - an=1101 and seg=~06=7'h79 4 cycles later;
  - sequence 1110,1101,1011,0111 repeats every 16 cycles.
- Change data to 16'hFFFF while idx=2 ->
  - digits 2 and 3 still show 2 and 3 in this frame;
  - all digits show F (seg=~71=7'h0E) from the next frame_tick onward.
- blank=4'b0100, dp=4'b0001 -> during slot 2, an=1111 and seg=7F; during slot 0, dp_out=0.
- Drop en for 10 cycles at idx=1, cnt=2 ->
  - outputs inactive from the next edge;
  - on re-enable, the slot-1 remainder lasts exactly 2 cycles before idx=2.
- Assert reset asynchronously mid-slot (between edges) -> an goes to 1111 immediately with no clk edge; cnt and idx are 0 after release.
- NDIGIT=1, ACTIVE_LOW=0, data=4'hA ->
  - an=1 and seg=7'h77 continuously;
  - frame_tick pulses every 4 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the seven-segment display path.
//   seg_t     : segment vector {g,f,e,d,c,b,a}, active-high
//   SEG_BLANK : all segments off
//   hex2seg   : hex nibble to active-high segment pattern
package display_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h00;

   // Entry i holds the pattern for nibble value i (index 15 listed first).
   localparam seg_t [15:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic seg_t hex2seg(input logic [3:0] h);
      return HEX_SEG[h];
   endfunction

endpackage

// File: rtl/display_scan_decoder.sv
// onehot_decoder: generalised digit-select decoder.
//   in  [W-1:0] : binary select
//   en          : 0 forces all outputs low
//   out [N-1:0] : one-hot decode of in, active-high
module onehot_decoder #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [W-1:0] in,
   input  logic         en,
   output logic [N-1:0] out
);

   always_comb begin
      out = '0;
      if (en) out = N'(1) << in;
   end

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed NDIGIT seven-segment display driver.
//   clk, reset  : clock (rising edge), async active-high reset
//   en          : scan enable; 0 holds scan state and blanks the pins
//   data        : one hex nibble per digit, digit i at data[4i+3:4i]
//   dp, blank   : per-digit decimal point request / force-dark
//   an          : one-hot digit select at the pins
//   seg, dp_out : segments {g,f,e,d,c,b,a} and decimal point at the pins
//   frame_tick  : one-cycle pulse the cycle after each frame start
// Pin polarity is set by ACTIVE_LOW (1 = all pins active-low).
module display_scan
   import display_pkg::*;
#(
   parameter int NDIGIT     = 8,
   parameter int DIV        = 100000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [4*NDIGIT-1:0] data,
   input  logic [NDIGIT-1:0]   dp,
   input  logic [NDIGIT-1:0]   blank,
   output logic [NDIGIT-1:0]   an,
   output logic [6:0]          seg,
   output logic                dp_out,
   output logic                frame_tick
);

   localparam int CW = $clog2(DIV);
   localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

   // Inactive pin levels; XOR with these turns active-high into pin polarity.
   localparam logic [NDIGIT-1:0] AN_OFF  = {NDIGIT{ACTIVE_LOW}};
   localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic              DP_OFF  = ACTIVE_LOW;

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*NDIGIT-1:0] sh_data_q;
   logic [NDIGIT-1:0]   sh_dp_q, sh_blank_q;
   logic                frame_tick_q;
   logic [NDIGIT-1:0]   an_q;
   logic [6:0]          seg_q;
   logic                dp_q;

   logic                frame_start;
   logic                lit;
   logic [3:0]          cur_nib;
   logic [NDIGIT-1:0]   an_raw;
   seg_t                seg_raw;
   logic                dp_raw;

   // Snapshot point: data only enters the shadow here, so a frame never tears.
   assign frame_start = en && (cnt_q == '0) && (idx_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (en) begin
         if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(NDIGIT - 1)) ? '0 : idx_q + IW'(1);
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Output stage works from the shadow copy, never from the live inputs.
   assign lit     = en & ~sh_blank_q[idx_q];
   assign cur_nib = sh_data_q[idx_q*4 +: 4];
   assign seg_raw = lit ? hex2seg(cur_nib) : SEG_BLANK;
   assign dp_raw  = lit & sh_dp_q[idx_q];

   onehot_decoder #(.N(NDIGIT), .W(IW)) u_dec (
      .in  (idx_q),
      .en  (lit),
      .out (an_raw)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         sh_data_q    <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '0;
         frame_tick_q <= 1'b0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         frame_tick_q <= frame_start;
         if (frame_start) begin
            sh_data_q  <= data;
            sh_dp_q    <= dp;
            sh_blank_q <= blank;
         end
         an_q  <= an_raw ^ AN_OFF;
         seg_q <= seg_raw ^ SEG_OFF;
         dp_q  <= dp_raw ^ DP_OFF;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp_out     = dp_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed self-checking bench for display_scan.
//   u_dut : NDIGIT=4, DIV=4, ACTIVE_LOW=1 (scan, snapshot, blank/dp, en hold, async reset)
//   u_one : NDIGIT=1, DIV=4, ACTIVE_LOW=0 (single digit, frame every slot)
module tb_display_scan;

   logic        clk = 1'b0;
   logic        reset, en;
   logic [15:0] data;
   logic [3:0]  dp, blank;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_out, frame_tick;

   logic        reset1, en1;
   logic [3:0]  data1;
   logic        dp1, blank1;
   logic        an1;
   logic [6:0]  seg1;
   logic        dp_out1, frame_tick1;

   int nchk = 0;
   int nfail = 0;
   int k = -1;

   always #5 clk = ~clk;

   display_scan #(.NDIGIT(4), .DIV(4), .ACTIVE_LOW(1'b1)) u_dut (
      .clk(clk), .reset(reset), .en(en), .data(data), .dp(dp), .blank(blank),
      .an(an), .seg(seg), .dp_out(dp_out), .frame_tick(frame_tick)
   );

   display_scan #(.NDIGIT(1), .DIV(4), .ACTIVE_LOW(1'b0)) u_one (
      .clk(clk), .reset(reset1), .en(en1), .data(data1), .dp(dp1), .blank(blank1),
      .an(an1), .seg(seg1), .dp_out(dp_out1), .frame_tick(frame_tick1)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, act, exp);
      end
   endtask

   // Advance one edge and settle; k counts edges since the first release.
   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg_tab [4] = '{7'h40, 7'h79, 7'h24, 7'h30};   // ~{3F,06,5B,4F}
   logic [3:0] an_hold [11] = '{4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b1110};

   initial begin
      int d;
      reset = 1'b1; en = 1'b1; data = 16'h3210; dp = 4'b0000; blank = 4'b0000;
      reset1 = 1'b1; en1 = 1'b1; data1 = 4'hA; dp1 = 1'b0; blank1 = 1'b0;

      // Reset state
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp_out), 32'h1);
      chk("rst_ft", 32'(frame_tick), 32'h0);
      chk("rst1_an", 32'(an1), 32'h0);
      chk("rst1_seg", 32'(seg1), 32'h0);
      chk("rst1_ft", 32'(frame_tick1), 32'h0);
      reset = 1'b0;

      // Two full frames of 3210
      for (int i = 0; i < 32; i++) begin
         step();
         d = (k / 4) % 4;
         chk("scan_an", 32'(an), 32'(an_tab[d]));
         chk("scan_seg", 32'(seg), 32'(seg_tab[d]));
         chk("scan_ft", 32'(frame_tick), 32'((k % 16) == 0));
         chk("scan_dp", 32'(dp_out), 32'h1);
      end

      // Data changes mid-frame (slot 2); visible only after next capture
      for (int i = 0; i < 32; i++) begin
         step();
         if (k == 40) data = 16'hFFFF;
         d = (k / 4) % 4;
         chk("snap_an", 32'(an), 32'(an_tab[d]));
         chk("snap_seg", 32'(seg), (k >= 49) ? 32'h0E : 32'(seg_tab[d]));
         chk("snap_ft", 32'(frame_tick), 32'((k % 16) == 0));
      end
      blank = 4'b0100; dp = 4'b0001;

      // Blanking and decimal point, captured at k=64
      for (int i = 0; i < 22; i++) begin
         step();
         d = (k / 4) % 4;
         if (k >= 65 && d == 2) begin
            chk("blk_an", 32'(an), 32'hF);
            chk("blk_seg", 32'(seg), 32'h7F);
            chk("blk_dp", 32'(dp_out), 32'h1);
         end else begin
            chk("blk_an", 32'(an), 32'(an_tab[d]));
            chk("blk_seg", 32'(seg), 32'h0E);
            chk("blk_dp", 32'(dp_out), (k >= 65 && d == 0) ? 32'h0 : 32'h1);
         end
         chk("blk_ft", 32'(frame_tick), 32'((k % 16) == 0));
      end

      // Hold at idx=1, cnt=2 for 10 cycles
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_an", 32'(an), 32'hF);
         chk("hold_seg", 32'(seg), 32'h7F);
         chk("hold_ft", 32'(frame_tick), 32'h0);
      end
      en = 1'b1;
      for (int i = 0; i < 11; i++) begin
         step();
         chk("resume_an", 32'(an), 32'(an_hold[i]));
         chk("resume_ft", 32'(frame_tick), 32'(i == 10));
      end

      // Asynchronous reset between edges
      step();
      #3;
      reset = 1'b1;
      #1;
      chk("arst_an", 32'(an), 32'hF);
      chk("arst_seg", 32'(seg), 32'h7F);
      step();
      chk("arst_hold_an", 32'(an), 32'hF);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rel_an", 32'(an), (i < 4) ? 32'hE : 32'hD);
         chk("rel_ft", 32'(frame_tick), 32'(i == 0));
         if (i == 0) chk("rel_seg0", 32'(seg), 32'h40);
         if (i == 1) begin
            chk("rel_seg1", 32'(seg), 32'h0E);
            chk("rel_dp1", 32'(dp_out), 32'h0);
         end
      end

      // Single digit, active-high
      reset1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("one_an", 32'(an1), 32'h1);
         chk("one_ft", 32'(frame_tick1), 32'((i % 4) == 0));
         chk("one_dp", 32'(dp_out1), 32'h0);
         if (i >= 1) chk("one_seg", 32'(seg1), 32'h77);
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
